key_encoder: RTL and testbench
==============================

# key_encoder

Registered encoder for the calculator's 13-button keypad. It samples the raw button lines, converts a single pressed button into a 4-bit key code, and raises a strobe while any button is held. It sits between the keypad pins and the calculator's input/operand logic, which consumes `keycode` whenever `keystrobe` is high.

## Interface

Parameters: none. Widths are fixed: 13 keys in, 4-bit code out.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-high.
  - The port keeps the codebase name `nrst`.
  - Asserted level is 1.
- `keypad`  in  13  raw button lines, 1 = pressed.
  - Bits 0–9 are digits 0–9.
  - Bit 10 is add, bit 11 is subtract, bit 12 is enter.
- `keycode`  out  4  encoded key, registered.
- `keystrobe`  out  1  1 while a key press is being reported, registered.

## Operation

- Stage 1: register `keypad` into `keypad_q` on every rising edge.
- Stage 2: encode `keypad_q` combinationally and register the result into `keycode` and `keystrobe`.
- Encoding of `keypad_q`:
  - Exactly one bit i set: `keycode = i` (0x0–0xC) and `keystrobe = 1`.
  - Two or more bits set: `keycode = 4'hF` (KEY_MULTI) and `keystrobe = 1`.
  - No bits set: `keystrobe = 0`, and `keycode` holds its previous value.
- Codes 0xD and 0xE are never produced.
- `keystrobe` is a level signal, not a pulse. It stays high for as long as the key is held, plus pipeline delay.
- No debounce is performed. Debouncing, if needed, is upstream.

## Timing

- Reset, asynchronous while `nrst = 1`:
  - `keypad_q = 0`, `keycode = 4'h0`, `keystrobe = 0`.
  - Outputs stay at these values for the whole reset, regardless of `keypad` or clock activity.
- Reset release: the first active sample is taken on the first rising edge after `nrst` falls.
- Latency is exactly 2 rising edges from `keypad` to outputs.
  - A change set up before edge N is registered at edge N.
  - It appears on `keycode`/`keystrobe` after edge N+1.
- Release: `keystrobe` falls 2 edges after all keypad bits return to 0, and `keycode` holds its last value.
- Key change without release (A to B): outputs switch directly to B's code 2 edges later, and `keystrobe` stays high.
- Reset mid-press: outputs go to reset values immediately. After release, the held key reappears 2 edges later.

## Structure

- Shared package `key_encoder_pkg` holds:
  - `keycode_t` (logic [3:0]).
  - Constants `KEY_ADD = 4'hA`, `KEY_SUB = 4'hB`, `KEY_ENTER = 4'hC`, `KEY_MULTI = 4'hF`, `NUM_KEYS = 13`.
- Sub-module `keypad_onehot_encode`, purely combinational:
  - Input: 13-bit vector.
  - Outputs: `code`, `any`, `multi`.
  - Uses a popcount or "more than one bit set" detector plus an index encoder.
  - Shared with any future keypad scanners.
- Top level holds only the two register stages and the hold-last-code mux.

## Test plan

- Reset: `nrst = 1` for 2 cycles with `keypad = 0`.
  - Required: `keycode = 0`, `keystrobe = 0`, both right after reset and one cycle later.
- Single keys: after reset, drive `keypad = 1 << i` for each i = 0..12 and check at the falling edge after 2 rising edges.
  - Required: `keycode = i` and `keystrobe = 1`.
  - This covers add (`13'h0400` → 0xA), subtract (`13'h0800` → 0xB) and enter (`13'h1000` → 0xC).
- Multi-press: `keypad = 13'b0000000000011`.
  - Required after 2 edges: `keycode = 4'hF`, `keystrobe = 1`.
- Reset while pressed: hold `nrst = 1` with `keypad = 13'b0000000000010` for 2 edges.
  - Required: `keycode = 0`, `keystrobe = 0`.
  - After reset release, `keycode = 1` and `keystrobe = 1` 2 edges later.
- Release and hold: press key 7 and wait 2 edges, then set `keypad = 0`.
  - After 1 edge: `keystrobe` is still 1.
  - After 2 edges: `keystrobe = 0` and `keycode = 7`.
- Direct change: from key 3 held, switch to key 9 without releasing.
  - Required: `keystrobe` stays 1 throughout, and `keycode` goes from 3 to 9 exactly 2 edges after the change.

Source files
------------

// File: rtl/key_encoder_pkg.sv
// ---------------------------------------------------------------------------
// key_encoder_pkg
// Shared types and constants for the calculator keypad encoder and any
// future keypad scanners that reuse the one-hot encoder.
//   keycode_t  : 4-bit encoded key value
//   NUM_KEYS   : number of raw button lines (digits 0-9, add, sub, enter)
//   KEY_*      : named codes for the non-digit keys and the multi-press code
// ---------------------------------------------------------------------------
package key_encoder_pkg;

    typedef logic [3:0] keycode_t;

    localparam int       NUM_KEYS  = 13;

    localparam keycode_t KEY_ADD   = 4'hA;
    localparam keycode_t KEY_SUB   = 4'hB;
    localparam keycode_t KEY_ENTER = 4'hC;
    localparam keycode_t KEY_MULTI = 4'hF;

    // Code reported after reset, before any key has ever been seen.
    localparam keycode_t KEY_RESET = 4'h0;

    // True when more than one bit of the key vector is set. Clearing the
    // lowest set bit leaves something behind only if a second bit exists.
    function automatic logic more_than_one(input logic [NUM_KEYS-1:0] keys);
        logic [NUM_KEYS-1:0] lowest_cleared;
        lowest_cleared = keys & (keys - {{(NUM_KEYS-1){1'b0}}, 1'b1});
        return |lowest_cleared;
    endfunction

endpackage

// File: rtl/key_encoder_onehot.sv
// ---------------------------------------------------------------------------
// keypad_onehot_encode
// Purely combinational encoder from a raw key vector to a 4-bit key code.
// Ports:
//   keys_i : NUM_KEYS-bit key vector, 1 = pressed
//   code   : bit index of the single pressed key, KEY_MULTI if more than one
//            key is pressed, 0 when nothing is pressed
//   any    : at least one key is pressed
//   multi  : two or more keys are pressed
// ---------------------------------------------------------------------------
module keypad_onehot_encode
    import key_encoder_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keys_i,
    output keycode_t            code,
    output logic                any,
    output logic                multi
);

    keycode_t index_d;

    // Index encoder: only meaningful when exactly one bit is set, which is
    // the only case where its result is passed through unmodified.
    always_comb begin
        index_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys_i[i]) begin
                index_d = keycode_t'(i);
            end
        end
    end

    assign any   = |keys_i;
    assign multi = more_than_one(keys_i);
    assign code  = multi ? KEY_MULTI : index_d;

endmodule

// File: rtl/key_encoder.sv
// ---------------------------------------------------------------------------
// key_encoder
// Registered encoder for the 13-button calculator keypad. The raw lines are
// sampled once, encoded, and the result registered, giving two clock edges
// of latency from keypad to outputs.
// Ports:
//   clk       : system clock, rising edge
//   nrst      : asynchronous reset, active HIGH despite the name
//   keypad    : raw button lines, bit 0-9 digits, 10 add, 11 sub, 12 enter
//   keycode   : encoded key, holds its last value when no key is pressed
//   keystrobe : high while a key press is being reported (level, not pulse)
// ---------------------------------------------------------------------------
module key_encoder
    import key_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_KEYS-1:0] keypad,
    output keycode_t            keycode,
    output logic                keystrobe
);

    logic [NUM_KEYS-1:0] keypad_q;
    keycode_t            keycode_q;
    keycode_t            keycode_d;
    logic                keystrobe_q;
    logic                keystrobe_d;

    keycode_t            enc_code;
    logic                enc_any;
    logic                enc_multi;

    keypad_onehot_encode u_encode (
        .keys_i (keypad_q),
        .code   (enc_code),
        .any    (enc_any),
        .multi  (enc_multi)
    );

    // Hold the last reported code while idle so downstream logic that looks
    // at keycode after the strobe drops still sees the last key.
    always_comb begin
        keycode_d   = keycode_q;
        keystrobe_d = enc_any;
        if (enc_any) begin
            keycode_d = enc_code;
        end
    end

    // Both pipeline stages share one reset; the reset name is historical,
    // the asserted level is 1.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            keypad_q    <= '0;
            keycode_q   <= KEY_RESET;
            keystrobe_q <= 1'b0;
        end else begin
            keypad_q    <= keypad;
            keycode_q   <= keycode_d;
            keystrobe_q <= keystrobe_d;
        end
    end

    assign keycode   = keycode_q;
    assign keystrobe = keystrobe_q;

endmodule

// File: tb/tb_key_encoder.sv
// ---------------------------------------------------------------------------
// tb_key_encoder
// Self-checking bench for key_encoder: directed scenarios plus a randomized
// run against a behavioural model of the keypad encoding rules.
// ---------------------------------------------------------------------------
module tb_key_encoder;

    logic        clk;
    logic        nrst;
    logic [12:0] keypad;
    logic [3:0]  keycode;
    logic        keystrobe;

    int checks = 0;
    int errors = 0;

    key_encoder dut (
        .clk       (clk),
        .nrst      (nrst),
        .keypad    (keypad),
        .keycode   (keycode),
        .keystrobe (keystrobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the encoding rules: code of one pressed key is its bit
    // position, several keys give 0xF, no key keeps the previous code.
    function automatic logic [3:0] model_code(input logic [12:0] v,
                                              input logic [3:0] prev);
        int n;
        n = $countones(v);
        if (n == 0)      return prev;
        else if (n == 1) return 4'($clog2(v));
        else             return 4'hF;
    endfunction

    task automatic test_reset();
        keypad = '0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++;
        if (keycode !== 4'h0 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got code=%h strobe=%b want 0/0", keycode, keystrobe);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++;
        if (keycode !== 4'h0 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: got code=%h strobe=%b want 0/0", keycode, keystrobe);
        end
        @(negedge clk);
        checks++;
        if (keycode !== 4'h0 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_plus1: got code=%h strobe=%b want 0/0", keycode, keystrobe);
        end
    endtask

    task automatic test_single_keys();
        logic [12:0] v;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            v = 13'd1 << i;
            keypad = v;
            repeat (2) @(posedge clk);
            @(negedge clk);
            checks++;
            if (keycode !== 4'(i) || keystrobe !== 1'b1) begin
                errors++;
                $display("FAIL single_key_%0d: got code=%h strobe=%b want %h/1",
                         i, keycode, keystrobe, 4'(i));
            end
        end
    endtask

    task automatic test_multi();
        @(negedge clk);
        keypad = 13'b0000000000011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (keycode !== 4'hF || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL multi_press: got code=%h strobe=%b want f/1", keycode, keystrobe);
        end
    endtask

    task automatic test_reset_mid_press();
        @(negedge clk);
        keypad = 13'b0000000000010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++;
        if (keycode !== 4'h0 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL midpress_async: got code=%h strobe=%b want 0/0", keycode, keystrobe);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (keycode !== 4'h0 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL midpress_held: got code=%h strobe=%b want 0/0", keycode, keystrobe);
        end
        nrst = 1'b0;
        @(negedge clk);
        checks++;
        if (keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL midpress_1edge: got strobe=%b want 0", keystrobe);
        end
        @(negedge clk);
        checks++;
        if (keycode !== 4'h1 || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL midpress_2edge: got code=%h strobe=%b want 1/1", keycode, keystrobe);
        end
    endtask

    task automatic test_release_hold();
        @(negedge clk);
        keypad = 13'd1 << 7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        keypad = '0;
        @(negedge clk);
        checks++;
        if (keycode !== 4'h7 || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL release_1edge: got code=%h strobe=%b want 7/1", keycode, keystrobe);
        end
        @(negedge clk);
        checks++;
        if (keycode !== 4'h7 || keystrobe !== 1'b0) begin
            errors++;
            $display("FAIL release_2edge: got code=%h strobe=%b want 7/0", keycode, keystrobe);
        end
    endtask

    task automatic test_direct_change();
        @(negedge clk);
        keypad = 13'd1 << 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (keycode !== 4'h3 || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL change_before: got code=%h strobe=%b want 3/1", keycode, keystrobe);
        end
        keypad = 13'd1 << 9;
        @(negedge clk);
        checks++;
        if (keycode !== 4'h3 || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL change_1edge: got code=%h strobe=%b want 3/1", keycode, keystrobe);
        end
        @(negedge clk);
        checks++;
        if (keycode !== 4'h9 || keystrobe !== 1'b1) begin
            errors++;
            $display("FAIL change_2edge: got code=%h strobe=%b want 9/1", keycode, keystrobe);
        end
    endtask

    // Random presses, releases and multi-presses. The value driven at a
    // negedge shows on the outputs two negedges later.
    task automatic test_random();
        logic [12:0] hist[$];
        logic [3:0]  last_code;
        logic [12:0] v;
        logic [3:0]  exp_code;
        logic        exp_strobe;
        int          kind;
        @(negedge clk);
        keypad = '0;
        repeat (3) @(negedge clk);
        last_code = keycode;
        for (int j = 0; j < 200; j++) begin
            if (j >= 2) begin
                v          = hist[j-2];
                exp_code   = model_code(v, last_code);
                exp_strobe = (v != 0);
                last_code  = exp_code;
                checks++;
                if (keycode !== exp_code || keystrobe !== exp_strobe) begin
                    errors++;
                    $display("FAIL random_%0d: in=%b got code=%h strobe=%b want %h/%b",
                             j, v, keycode, keystrobe, exp_code, exp_strobe);
                end
            end
            kind = int'($urandom_range(9, 0));
            if (kind < 4)      v = '0;
            else if (kind < 8) v = 13'd1 << $urandom_range(12, 0);
            else               v = 13'($urandom);
            hist.push_back(v);
            keypad = v;
            @(negedge clk);
        end
    endtask

    initial begin
        nrst   = 1'b0;
        keypad = '0;
        $display("[TB] starting key_encoder tests");
        test_reset();
        test_single_keys();
        test_multi();
        test_reset_mid_press();
        test_release_hold();
        test_direct_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
